// File: rtl/fifo_stream_reader_pkg.sv
// Shared FIFO definitions: common FIFO geometry and the output-buffer state type
// used by the FIFO stream reader.
package fifo_stream_reader_pkg;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_WIDTH = 8;
  localparam int unsigned BUF_DEPTH  = 2;
  localparam int unsigned OCC_W      = 2;

  // Encoding equals the number of words held, so occupancy is the state value
  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  function automatic logic [OCC_W-1:0] occ_of(input buf_state_t s);
    return OCC_W'(s);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read-port plus valid/ready stream bundle between the reader and its
// environment; master is the reader side.
interface fifo_stream_reader_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_read;
  logic             flush;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, flush, m_ready,
    output fifo_read, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, flush, m_ready,
    input  fifo_read, m_valid, m_data
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// Converts a sync FIFO pop/one-cycle-latency read port into a valid/ready
// stream through a 2-entry ordered output buffer, counting accepted words.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_stream_reader_if.master  bus,
  output logic [CNT_W-1:0]      word_cnt
);

  buf_state_t       state;
  buf_state_t       state_nx;
  logic             inflight;
  logic [WIDTH-1:0] buf0;
  logic [WIDTH-1:0] buf1;
  logic [WIDTH-1:0] buf0_nx;
  logic [WIDTH-1:0] buf1_nx;
  logic             valid;
  logic             accept;
  logic             capture;
  logic             pop;
  logic [OCC_W-1:0] slots_used;

  assign valid   = (state != EMPTY);
  assign accept  = valid & bus.m_ready;
  // An arriving word is dropped when a flush coincides with its capture cycle
  assign capture = inflight & ~bus.flush;

  // A same-cycle accept frees a slot, which keeps one pop per cycle when streaming
  assign slots_used = occ_of(state) + OCC_W'(inflight) - OCC_W'(accept);
  assign pop        = rst_n & ~bus.fifo_empty & ~bus.flush
                      & (slots_used < OCC_W'(BUF_DEPTH));

  assign bus.fifo_read = pop;
  assign bus.m_valid   = valid;
  assign bus.m_data    = buf0;

  // Next buffer state and contents; buf0 is always the oldest word
  always_comb begin
    state_nx = state;
    buf0_nx  = buf0;
    buf1_nx  = buf1;
    if (bus.flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (capture) begin
            buf0_nx  = bus.fifo_data;
            state_nx = ONE;
          end
        end
        ONE: begin
          case ({capture, accept})
            2'b10: begin
              buf1_nx  = bus.fifo_data;
              state_nx = TWO;
            end
            2'b01:   state_nx = EMPTY;
            2'b11:   buf0_nx  = bus.fifo_data;
            default: state_nx = ONE;
          endcase
        end
        TWO: begin
          if (accept) begin
            buf0_nx = buf1;
            if (capture) begin
              buf1_nx = bus.fifo_data;
            end else begin
              state_nx = ONE;
            end
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      state    <= state_nx;
      inflight <= pop;
      buf0     <= buf0_nx;
      buf1     <= buf1_nx;
    end
  end

  // Delivered-word counter, wraps naturally; flush does not touch it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader paired with an 8x8 sync FIFO model; scoreboard
// of written words checked against every accepted stream word.
module tb_fifo_stream_reader;
  import fifo_stream_reader_pkg::*;

  localparam int unsigned WIDTH  = FIFO_WIDTH;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT_W4 = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fifo_rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();
  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus4 ();
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W4-1:0] word_cnt4;

  fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .word_cnt(word_cnt));

  // Narrow-counter twin sees identical inputs, so it tracks the same stream
  fifo_stream_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .word_cnt(word_cnt4));

  assign bus4.fifo_empty = bus.fifo_empty;
  assign bus4.fifo_data  = bus.fifo_data;
  assign bus4.flush      = bus.flush;
  assign bus4.m_ready    = bus.m_ready;

  // Sync FIFO model, DEPTH 8, read data registered one cycle after the pop
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [2:0]       rptr, wptr;
  logic [3:0]       fcnt;
  logic [WIDTH-1:0] rd_data;
  logic             do_rd, do_wr;

  assign do_rd = bus.fifo_read && (fcnt != 4'd0);
  assign do_wr = wr_en && (fcnt != 4'(FIFO_DEPTH));
  assign bus.fifo_empty = (fcnt == 4'd0);
  assign bus.fifo_data  = rd_data;

  always @(posedge clk) if (do_wr) mem[wptr] <= wr_data;

  always @(posedge clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      rptr <= 3'd0; wptr <= 3'd0; fcnt <= 4'd0; rd_data <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 3'd1;
      if (do_rd) begin
        rd_data <= mem[rptr];
        rptr    <= rptr + 3'd1;
      end
      fcnt <= fcnt + 4'(do_wr) - 4'(do_rd);
    end
  end

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_v;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int outstanding = 0;
  int pop_total = 0;
  int acc_cyc_q [$];
  int empty_fall_cyc = -1;
  logic empty_prev = 1'b1;
  logic pop_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: committed handshakes of each cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      while (outstanding > 0 && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        outstanding--;
      end
      outstanding = 0;
      pop_prev = 1'b0;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_data: got %h, expected no word (scoreboard empty)", bus.m_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.m_data !== exp_v) begin
            n_err++;
            $display("FAIL sb_data: got %h, expected %h at cycle %0d", bus.m_data, exp_v, cyc);
          end
        end
        outstanding--;
        acc_cyc_q.push_back(cyc);
      end
      if (bus.flush) begin
        while (outstanding > 0 && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          outstanding--;
        end
        outstanding = 0;
      end
      if (bus.fifo_read) begin
        outstanding++;
        pop_total++;
      end
      n_cmp++;
      if (outstanding > 2 || outstanding < 0) begin
        n_err++;
        $display("FAIL occupancy: occ+inflight is %0d, expected 0..2 at cycle %0d", outstanding, cyc);
      end
      if (!bus.fifo_empty && empty_prev) empty_fall_cyc = cyc;
      empty_prev = bus.fifo_empty;
      pop_prev   = bus.fifo_read;
    end
  end

  task automatic wait_drain(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    ok = (exp_q.size() == 0);
  endtask

  task automatic push_write(input logic [WIDTH-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fifo_rst_n = 1'b0; wr_en = 1'b0; wr_data = '0;
    bus.flush = 1'b0; bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h, expected 00", bus.m_data); end
    n_cmp++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d, expected 0", word_cnt); end
    n_cmp++; if (bus.fifo_read !== 1'b0) begin n_err++; $display("FAIL reset_read: got %b, expected 0", bus.fifo_read); end
    fifo_rst_n = 1'b1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %b, expected 0", bus.m_valid); end
  endtask

  task automatic test_stream();
    logic ok;
    bus.m_ready = 1'b1;
    acc_cyc_q.delete();
    for (int i = 1; i <= 8; i++) push_write(8'(i));
    wr_en = 1'b0;
    wait_drain(50, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL stream_drain: %0d words left, expected 0", exp_q.size()); end
    n_cmp++;
    if (acc_cyc_q.size() != 8) begin
      n_err++; $display("FAIL stream_count: got %0d accepts, expected 8", acc_cyc_q.size());
    end else begin
      if (acc_cyc_q[0] - empty_fall_cyc != 2) begin
        n_err++; $display("FAIL stream_latency: got %0d cycles, expected 2", acc_cyc_q[0] - empty_fall_cyc);
      end
      n_cmp++;
      if (acc_cyc_q[7] - acc_cyc_q[0] != 7) begin
        n_err++; $display("FAIL stream_rate: 8 words took %0d cycles span, expected 7", acc_cyc_q[7] - acc_cyc_q[0]);
      end
    end
    n_cmp++; if (word_cnt !== 16'd8) begin n_err++; $display("FAIL stream_cnt: got %0d, expected 8", word_cnt); end
    n_cmp++; if (word_cnt4 !== 4'd8) begin n_err++; $display("FAIL stream_cnt4: got %0d, expected 8", word_cnt4); end
  endtask

  task automatic test_backpressure();
    logic ok;
    int p0;
    bus.m_ready = 1'b0;
    p0 = pop_total;
    for (int i = 0; i < 4; i++) push_write(8'(8'hA0 + i));
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b, expected 1 (cycle %0d)", bus.m_valid, i); end
      n_cmp++; if (bus.m_data !== 8'hA0) begin n_err++; $display("FAIL bp_hold: got %h, expected a0 (cycle %0d)", bus.m_data, i); end
    end
    n_cmp++; if (pop_total - p0 != 2) begin n_err++; $display("FAIL bp_pops: got %0d pops, expected 2", pop_total - p0); end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    wait_drain(30, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_drain: %0d words left, expected 0", exp_q.size()); end
    n_cmp++; if (word_cnt !== 16'd12) begin n_err++; $display("FAIL bp_cnt: got %0d, expected 12", word_cnt); end
  endtask

  task automatic test_random();
    int written = 0;
    logic [WIDTH-1:0] d;
    for (int c = 0; c < 4000 && !(written == 200 && exp_q.size() == 0); c++) begin
      bus.m_ready = 1'($urandom_range(0, 1));
      if (written < 200 && fcnt < 4'(FIFO_DEPTH) && $urandom_range(0, 3) != 0) begin
        d = 8'($urandom);
        wr_en = 1'b1; wr_data = d;
        exp_q.push_back(d);
        written++;
      end else begin
        wr_en = 1'b0;
      end
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    n_cmp++; if (written != 200 || exp_q.size() != 0) begin
      n_err++; $display("FAIL rand_drain: wrote %0d, %0d left, expected 200 and 0", written, exp_q.size());
    end
    n_cmp++; if (word_cnt !== 16'd212) begin n_err++; $display("FAIL rand_cnt: got %0d, expected 212", word_cnt); end
  endtask

  task automatic test_flush();
    bus.m_ready = 1'b0;
    push_write(8'h30);
    push_write(8'h31);
    wr_en = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.m_valid !== 1'b1 || pop_prev !== 1'b1) begin
      n_err++; $display("FAIL flush_setup: valid %b pop_prev %b, expected 1 1", bus.m_valid, pop_prev);
    end
    bus.flush = 1'b1;
    #1;
    n_cmp++; if (bus.fifo_read !== 1'b0) begin n_err++; $display("FAIL flush_read: got %b, expected 0", bus.fifo_read); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b, expected 0", bus.m_valid); end
    n_cmp++; if (word_cnt !== 16'd212) begin n_err++; $display("FAIL flush_cnt: got %0d, expected 212", word_cnt); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost: valid %b data %h, expected 0", bus.m_valid, bus.m_data); end
    end
    @(posedge clk); #1;
    push_write(8'h55);
    wr_en = 1'b0;
    for (int i = 0; i < 10 && !bus.m_valid; i++) begin @(posedge clk); #1; end
    n_cmp++; if (bus.m_valid !== 1'b1) begin n_err++; $display("FAIL post_flush_valid: got %b, expected 1", bus.m_valid); end
    n_cmp++; if (bus.m_data !== 8'h55) begin n_err++; $display("FAIL post_flush_data: got %h, expected 55", bus.m_data); end
    bus.m_ready = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0; bus.flush = 1'b0;
    n_cmp++; if (word_cnt !== 16'd213) begin n_err++; $display("FAIL flush_accept_cnt: got %0d, expected 213", word_cnt); end
    n_cmp++; if (bus.m_valid !== 1'b0) begin n_err++; $display("FAIL flush_accept_valid: got %b, expected 0", bus.m_valid); end
  endtask

  task automatic test_wrap_and_async_reset();
    logic ok;
    rst_n = 1'b0; fifo_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; fifo_rst_n = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_write(8'(8'h80 + i));
    wr_en = 1'b0;
    wait_drain(60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_drain: %0d words left, expected 0", exp_q.size()); end
    n_cmp++; if (word_cnt4 !== 4'd1) begin n_err++; $display("FAIL wrap_cnt4: got %0d, expected 1", word_cnt4); end
    n_cmp++; if (word_cnt !== 16'd17) begin n_err++; $display("FAIL wrap_cnt: got %0d, expected 17", word_cnt); end
    // Mid-stream reset with words still queued in the FIFO
    bus.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push_write(8'(8'h60 + i));
    wr_en = 1'b0;
    bus.m_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.m_valid !== 1'b0 || bus4.m_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b/%b, expected 0/0", bus.m_valid, bus4.m_valid); end
    n_cmp++; if (bus.m_data !== 8'h00 || bus4.m_data !== 8'h00) begin n_err++; $display("FAIL async_data: got %h/%h, expected 00/00", bus.m_data, bus4.m_data); end
    n_cmp++; if (word_cnt !== 16'd0 || word_cnt4 !== 4'd0) begin n_err++; $display("FAIL async_cnt: got %0d/%0d, expected 0/0", word_cnt, word_cnt4); end
    n_cmp++; if (bus.fifo_read !== 1'b0 || bus4.fifo_read !== 1'b0) begin n_err++; $display("FAIL async_read: got %b/%b, expected 0/0", bus.fifo_read, bus4.fifo_read); end
    n_cmp++; if (bus.fifo_empty !== 1'b0) begin n_err++; $display("FAIL async_fifo: empty %b, expected 0 (words kept)", bus.fifo_empty); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain(40, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_drain: %0d words left, expected 0", exp_q.size()); end
    n_cmp++; if (word_cnt !== 16'd3) begin n_err++; $display("FAIL rst_cnt: got %0d, expected 3", word_cnt); end
    n_cmp++; if (word_cnt4 !== 4'd3) begin n_err++; $display("FAIL rst_cnt4: got %0d, expected 3", word_cnt4); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
    test_wrap_and_async_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL final_queue: %0d words undelivered, expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
